// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state and the bundled
// per-stage stall/flush controls consumed by the stage registers.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MULDIV   = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE    = pipe_ctl_t'(8'b0000_0000);
  localparam pipe_ctl_t CTL_MEM     = pipe_ctl_t'(8'b1111_0001);
  localparam pipe_ctl_t CTL_MULDIV  = pipe_ctl_t'(8'b1110_0010);
  localparam pipe_ctl_t CTL_REDIR   = pipe_ctl_t'(8'b0000_1100);
  localparam pipe_ctl_t CTL_LOADUSE = pipe_ctl_t'(8'b1100_0100);
  localparam pipe_ctl_t CTL_IMEM    = pipe_ctl_t'(8'b1000_1000);

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Pure combinational load-use hazard compare between the E-stage load and the
// D-stage source operands; x0 never creates a dependency.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  output logic              load_use
);

  logic hitRs1;
  logic hitRs2;

  assign hitRs1   = id_uses_rs1 && (ex_rd == id_rs1);
  assign hitRs2   = id_uses_rs2 && (ex_rd == id_rs2);
  assign load_use = ex_is_load && (ex_rd != '0) && (hitRs1 || hitRs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the F/D/E/M/W pipeline registers.
// Optional perf counters are built only when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  input  logic              muldiv_start,
  input  logic              muldiv_done,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              fetch_redir,
  output logic [XLEN-1:0]   fetch_pc,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  hz_state_t       state;
  hz_state_t       nextState;
  logic            redirPend;
  logic            redirPendNext;
  logic [XLEN-1:0] redirPc;
  logic [XLEN-1:0] redirPcNext;
  logic            mdvPend;
  logic            mdvPendNext;
  logic            mdvInFlight;
  logic            loadUse;
  logic            redirApply;
  logic [XLEN-1:0] pcOut;
  pipe_ctl_t       ctl;

  hazard_detect #(.REG_AW(REG_AW)) uDetect (
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (loadUse)
  );

  // A mul/div interrupted by dmem_busy stays owed through MEM_WAIT via mdvPend.
  assign mdvInFlight = (state == MULDIV) || ((state == MEM_WAIT) && mdvPend);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      redirPend <= 1'b0;
      redirPc   <= '0;
      mdvPend   <= 1'b0;
    end else begin
      state     <= nextState;
      redirPend <= redirPendNext;
      redirPc   <= redirPcNext;
      mdvPend   <= mdvPendNext;
    end
  end

  always_comb begin
    ctl           = CTL_IDLE;
    nextState     = RUN;
    mdvPendNext   = 1'b0;
    redirApply    = 1'b0;
    pcOut         = '0;
    redirPendNext = redirPend;
    redirPcNext   = redirPc;
    if (!reset) begin
      if (dmem_busy) begin
        ctl         = CTL_MEM;
        nextState   = MEM_WAIT;
        mdvPendNext = mdvInFlight && !muldiv_done;
      end else if (mdvInFlight ? !muldiv_done : (muldiv_start && !muldiv_done)) begin
        ctl       = CTL_MULDIV;
        nextState = MULDIV;
      end else if (redirPend || redirect_valid) begin
        ctl           = CTL_REDIR;
        redirApply    = 1'b1;
        pcOut         = redirPend ? redirPc : redirect_pc;
        redirPendNext = 1'b0;
      end else if (loadUse) begin
        ctl = CTL_LOADUSE;
      end else if (imem_busy) begin
        ctl = CTL_IMEM;
      end
      // E is frozen while a redirect is owed, so a repeated redirect_valid is the same branch.
      if (redirect_valid && !redirPend && !redirApply) begin
        redirPendNext = 1'b1;
        redirPcNext   = redirect_pc;
      end
    end
  end

  assign stall_f     = ctl.stall_f;
  assign stall_d     = ctl.stall_d;
  assign stall_e     = ctl.stall_e;
  assign stall_m     = ctl.stall_m;
  assign flush_d     = ctl.flush_d;
  assign flush_e     = ctl.flush_e;
  assign flush_m     = ctl.flush_m;
  assign flush_w     = ctl.flush_w;
  assign fetch_redir = redirApply;
  assign fetch_pc    = pcOut;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] stallCyc;
  logic [PERF_W-1:0] flushCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCyc <= '0;
      flushCnt <= '0;
    end else begin
      if (ctl.stall_f) stallCyc <= stallCyc + 1'b1;
      if (redirApply)  flushCnt <= flushCnt + 1'b1;
    end
  end

  assign perf_stall_cyc = stallCyc;
  assign perf_flush_cnt = flushCnt;
`else
  assign perf_stall_cyc = {PERF_W{1'b0}};
  assign perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule
